// File: rtl/fpu_bus_slave_pkg.sv
// Shared FPU definitions: operation codes, bus register map, bus-slave FSM
// states and the quiet-NaN pattern loaded on aborted commands.
package pa_fpu;

  typedef enum logic [1:0] {
    op_add = 2'd0,
    op_sub = 2'd1,
    op_mul = 2'd2,
    op_div = 2'd3
  } e_fpu_operations;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_DONE
  } e_bus_state;

  localparam logic [3:0] ADDR_A0     = 4'h0;
  localparam logic [3:0] ADDR_A1     = 4'h1;
  localparam logic [3:0] ADDR_A2     = 4'h2;
  localparam logic [3:0] ADDR_A3     = 4'h3;
  localparam logic [3:0] ADDR_B0     = 4'h4;
  localparam logic [3:0] ADDR_B1     = 4'h5;
  localparam logic [3:0] ADDR_B2     = 4'h6;
  localparam logic [3:0] ADDR_B3     = 4'h7;
  localparam logic [3:0] ADDR_OP     = 4'h8;
  localparam logic [3:0] ADDR_R0     = 4'h9;
  localparam logic [3:0] ADDR_R1     = 4'hA;
  localparam logic [3:0] ADDR_R2     = 4'hB;
  localparam logic [3:0] ADDR_R3     = 4'hC;
  localparam logic [3:0] ADDR_STATUS = 4'hD;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_CMD_END = 1;
  localparam int STAT_ILLEGAL = 2;
  localparam int STAT_TIMEOUT = 3;

  // Only the four arithmetic codes launch the core; anything else is illegal.
  function automatic logic op_is_legal(input logic [7:0] code);
    return code < 8'd4;
  endfunction

endpackage

// File: rtl/fpu_bus_slave_if.sv
// CPU-side bus of the FPU bus slave: byte data, address, active-low strobes
// and the command-end handshake.
interface fpu_bus_slave_if;
  logic [7:0] databus_in;
  logic [7:0] databus_out;
  logic [3:0] addr;
  logic       cs;
  logic       rd;
  logic       wr;
  logic       end_ack;
  logic       cmd_end;
  logic       busy;

  modport slave (
    input  databus_in, addr, cs, rd, wr, end_ack,
    output databus_out, cmd_end, busy
  );

  modport master (
    output databus_in, addr, cs, rd, wr, end_ack,
    input  databus_out, cmd_end, busy
  );
endinterface

// File: rtl/fpu_bus_slave.sv
// Byte-wide register-file front end for the FPU core. Collects operands,
// launches the core on an op write, times out a silent core, and hands the
// result back through a cmd_end / end_ack handshake.
module fpu_bus_slave
  import pa_fpu::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic                  clk,
  input  logic                  arst_n,
  fpu_bus_slave_if.slave        bus,
  output logic                  core_start,
  output e_fpu_operations       core_op,
  output logic [31:0]           core_a,
  output logic [31:0]           core_b,
  input  logic                  core_done,
  input  logic [31:0]           core_result
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  e_bus_state      state_q, state_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     res_q, res_d;
  e_fpu_operations op_q, op_d;
  logic            ill_q, ill_d;
  logic            to_q, to_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            wr_prev_q;

  logic            wr_commit;
  logic            busy_w;
  logic            end_w;
  logic [7:0]      status_w;
  logic [7:0]      rdata;

  // A write commits only on the first edge of a wr low pulse.
  assign wr_commit = !bus.cs && !bus.wr && wr_prev_q;
  assign busy_w    = (state_q == ST_START) || (state_q == ST_WAIT);
  assign end_w     = (state_q == ST_DONE);

  // Previous sample of wr; reset high so a fresh pulse is recognised.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) wr_prev_q <= 1'b1;
    else         wr_prev_q <= bus.wr;
  end

  // Register file, flags, timeout counter and FSM state.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= op_add;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: operand writes, command launch, completion and timeout.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    ill_d   = ill_q;
    to_d    = to_q;
    cnt_d   = cnt_q;

    // Operands stay frozen while the core is working on them.
    if (wr_commit && !busy_w) begin
      if (bus.addr[3:2] == 2'b00)
        a_d[{bus.addr[1:0], 3'b000} +: 8] = bus.databus_in;
      else if (bus.addr[3:2] == 2'b01)
        b_d[{bus.addr[1:0], 3'b000} +: 8] = bus.databus_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_commit && (bus.addr == ADDR_OP)) begin
          if (op_is_legal(bus.databus_in)) begin
            op_d    = e_fpu_operations'(bus.databus_in[1:0]);
            ill_d   = 1'b0;
            to_d    = 1'b0;
            state_d = ST_START;
          end else begin
            ill_d   = 1'b1;
            to_d    = 1'b0;
            res_d   = QNAN;
            state_d = ST_DONE;
          end
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion on the last allowed cycle still counts as success.
        if (core_done) begin
          res_d   = core_result;
          state_d = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          to_d    = 1'b1;
          res_d   = QNAN;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.end_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status byte assembled from the live FSM state and sticky flags.
  always_comb begin
    status_w               = 8'h00;
    status_w[STAT_BUSY]    = busy_w;
    status_w[STAT_CMD_END] = end_w;
    status_w[STAT_ILLEGAL] = ill_q;
    status_w[STAT_TIMEOUT] = to_q;
  end

  // Combinational read mux; the bus floats to zero unless selected and read.
  always_comb begin
    rdata = 8'h00;
    if (!bus.cs && !bus.rd) begin
      case (bus.addr)
        ADDR_A0:     rdata = a_q[7:0];
        ADDR_A1:     rdata = a_q[15:8];
        ADDR_A2:     rdata = a_q[23:16];
        ADDR_A3:     rdata = a_q[31:24];
        ADDR_B0:     rdata = b_q[7:0];
        ADDR_B1:     rdata = b_q[15:8];
        ADDR_B2:     rdata = b_q[23:16];
        ADDR_B3:     rdata = b_q[31:24];
        ADDR_OP:     rdata = {6'b000000, op_q};
        ADDR_R0:     rdata = res_q[7:0];
        ADDR_R1:     rdata = res_q[15:8];
        ADDR_R2:     rdata = res_q[23:16];
        ADDR_R3:     rdata = res_q[31:24];
        ADDR_STATUS: rdata = status_w;
        default:     rdata = 8'h00;
      endcase
    end
  end

  assign bus.databus_out = rdata;
  assign bus.cmd_end     = end_w;
  assign bus.busy        = busy_w;
  assign core_start      = (state_q == ST_START);
  assign core_op         = op_q;
  assign core_a          = a_q;
  assign core_b          = b_q;

endmodule
